// File: rtl/layer_sched.sv
// layer_sched: network-level sequencer above batch_ctrl. Holds a host-written
// table of per-layer descriptors and, per layer, walks batch_ctrl through a
// weight-load phase, a bias-load phase and a batch-run phase, ending each phase
// by counting beats on the monitored AXI streams.
module layer_sched #(
  parameter int NL = 8,
  parameter int LW = 3,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_layer,
  input  logic [2:0]    cfg_sel,
  input  logic [15:0]   cfg_data,
  input  logic [LW:0]   nlayers,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] cur_layer,
  output logic          run,
  output logic          wwrite,
  output logic          bwrite,
  output logic          backprop,
  output logic          last,
  output logic [11:0]   ss,
  output logic [11:0]   ds,
  output logic [3:0]    id,
  output logic [3:0]    od,
  output logic [9:0]    fs,
  output logic [9:0]    ks,
  input  logic          src_valid,
  input  logic          src_ready,
  input  logic          src_last,
  input  logic          dst_valid,
  input  logic          dst_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WPRM, S_BPRM, S_GAP, S_RUN, S_NEXT
  } state_t;

  // descriptor table (deliberately not reset so it survives a reset pulse)
  logic [11:0]   t_ss    [NL];
  logic [11:0]   t_ds    [NL];
  logic [3:0]    t_id    [NL];
  logic [3:0]    t_od    [NL];
  logic [9:0]    t_fs    [NL];
  logic [9:0]    t_ks    [NL];
  logic [1:0]    t_flags [NL];
  logic [SW-1:0] t_nsamp [NL];

  state_t        state_q, state_d;
  logic [LW-1:0] cur_layer_q, cur_layer_d;
  logic [23:0]   wcnt_q, wcnt_d;
  logic [SW-1:0] samp_in_q, samp_in_d;
  logic [SW-1:0] samp_out_q, samp_out_d;
  logic [11:0]   beat_q, beat_d;
  logic          gap_run_q, gap_run_d;
  logic [SW-1:0] nsamp_q, nsamp_d;
  logic          bp_q, bp_d;
  logic [11:0]   ss_q, ss_d, ds_q, ds_d;
  logic [3:0]    id_q, id_d, od_q, od_d;
  logic [9:0]    fs_q, fs_d, ks_q, ks_d;
  logic          busy_q, busy_d, done_q, done_d, run_q, run_d;
  logic          wwrite_q, wwrite_d, bwrite_q, bwrite_d, last_q, last_d;

  logic [4:0]    nw_i_s, nw_o_s;
  logic [10:0]   nw_k_s;
  logic [23:0]   nw_s;
  logic [SW-1:0] nsamp_eff_s;

  // weight-word count for the latched layer and effective sample count
  always_comb begin
    nw_i_s      = bp_q ? ({1'b0, id_q} + 5'd1) : 5'd1;
    nw_o_s      = {1'b0, od_q} + 5'd1;
    nw_k_s      = {1'b0, (bp_q ? ks_q : fs_q)} + 11'd1;
    nw_s        = {19'd0, nw_i_s} * {19'd0, nw_o_s} * {13'd0, nw_k_s};
    nsamp_eff_s = (nsamp_q == SW'(0)) ? SW'(1) : nsamp_q;
  end

  // host writes into the descriptor table, accepted only while idle
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == S_IDLE)) begin
      case (cfg_sel)
        3'd0:    t_ss[cfg_layer]    <= cfg_data[11:0];
        3'd1:    t_ds[cfg_layer]    <= cfg_data[11:0];
        3'd2:    begin
                   t_id[cfg_layer]  <= cfg_data[7:4];
                   t_od[cfg_layer]  <= cfg_data[3:0];
                 end
        3'd3:    t_fs[cfg_layer]    <= cfg_data[9:0];
        3'd4:    t_ks[cfg_layer]    <= cfg_data[9:0];
        3'd5:    t_flags[cfg_layer] <= cfg_data[1:0];
        3'd6:    t_nsamp[cfg_layer] <= cfg_data[SW-1:0];
        default: ;
      endcase
    end
  end

  // next-state, counters and the registered control outputs
  always_comb begin
    state_d     = state_q;
    cur_layer_d = cur_layer_q;
    wcnt_d      = wcnt_q;
    samp_in_d   = samp_in_q;
    samp_out_d  = samp_out_q;
    beat_d      = beat_q;
    gap_run_d   = gap_run_q;
    nsamp_d     = nsamp_q;
    bp_d        = bp_q;
    ss_d        = ss_q;
    ds_d        = ds_q;
    id_d        = id_q;
    od_d        = od_q;
    fs_d        = fs_q;
    ks_d        = ks_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_layer_d = LW'(0);
          if (nlayers != (LW+1)'(0)) begin
            state_d = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        ss_d       = t_ss[cur_layer_q];
        ds_d       = t_ds[cur_layer_q];
        id_d       = t_id[cur_layer_q];
        od_d       = t_od[cur_layer_q];
        fs_d       = t_fs[cur_layer_q];
        ks_d       = t_ks[cur_layer_q];
        bp_d       = t_flags[cur_layer_q][0];
        nsamp_d    = t_nsamp[cur_layer_q];
        wcnt_d     = 24'd0;
        samp_in_d  = SW'(0);
        samp_out_d = SW'(0);
        beat_d     = 12'd0;
        if (t_flags[cur_layer_q][1]) begin
          state_d   = S_GAP;
          gap_run_d = 1'b1;
        end else begin
          state_d = S_WPRM;
        end
      end
      S_WPRM: begin
        // beats counted on valid alone, as batch_ctrl counts parameters
        if (src_valid) begin
          if (wcnt_q == nw_s - 24'd1) begin
            wcnt_d    = 24'd0;
            state_d   = S_GAP;
            gap_run_d = bp_q;
          end else begin
            wcnt_d = wcnt_q + 24'd1;
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      S_BPRM: begin
        if (src_valid) begin
          if (wcnt_q == {20'd0, od_q}) begin
            wcnt_d    = 24'd0;
            state_d   = S_GAP;
            gap_run_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 24'd1;
          end
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      S_GAP: begin
        state_d = gap_run_q ? S_RUN : S_BPRM;
      end
      S_RUN: begin
        if (src_valid && src_ready && src_last) begin
          samp_in_d = samp_in_q + SW'(1);
        end else begin
          samp_in_d = samp_in_q;
        end
        if (dst_valid && dst_ready) begin
          if (beat_q == ds_q) begin
            beat_d     = 12'd0;
            samp_out_d = samp_out_q + SW'(1);
            if (samp_out_d == nsamp_eff_s) begin
              state_d = S_NEXT;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            beat_d = beat_q + 12'd1;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      S_NEXT: begin
        if (({1'b0, cur_layer_q} + (LW+1)'(1)) < nlayers) begin
          cur_layer_d = cur_layer_q + LW'(1);
          state_d     = S_LOAD;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort beats any phase completion decided above
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
      state_d = state_d;
    end

    busy_d   = (state_d != S_IDLE);
    run_d    = (state_d == S_RUN);
    wwrite_d = (state_d == S_WPRM);
    bwrite_d = (state_d == S_BPRM);
    last_d   = (state_d == S_RUN) && (samp_in_d >= nsamp_eff_s - SW'(1));
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_layer_q <= LW'(0);
      wcnt_q      <= 24'd0;
      samp_in_q   <= SW'(0);
      samp_out_q  <= SW'(0);
      beat_q      <= 12'd0;
      gap_run_q   <= 1'b0;
      nsamp_q     <= SW'(0);
      bp_q        <= 1'b0;
      ss_q        <= 12'd0;
      ds_q        <= 12'd0;
      id_q        <= 4'd0;
      od_q        <= 4'd0;
      fs_q        <= 10'd0;
      ks_q        <= 10'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      run_q       <= 1'b0;
      wwrite_q    <= 1'b0;
      bwrite_q    <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_layer_q <= cur_layer_d;
      wcnt_q      <= wcnt_d;
      samp_in_q   <= samp_in_d;
      samp_out_q  <= samp_out_d;
      beat_q      <= beat_d;
      gap_run_q   <= gap_run_d;
      nsamp_q     <= nsamp_d;
      bp_q        <= bp_d;
      ss_q        <= ss_d;
      ds_q        <= ds_d;
      id_q        <= id_d;
      od_q        <= od_d;
      fs_q        <= fs_d;
      ks_q        <= ks_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      run_q       <= run_d;
      wwrite_q    <= wwrite_d;
      bwrite_q    <= bwrite_d;
      last_q      <= last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cur_layer = cur_layer_q;
  assign run       = run_q;
  assign wwrite    = wwrite_q;
  assign bwrite    = bwrite_q;
  assign backprop  = bp_q;
  assign last      = last_q;
  assign ss        = ss_q;
  assign ds        = ds_q;
  assign id        = id_q;
  assign od        = od_q;
  assign fs        = fs_q;
  assign ks        = ks_q;

endmodule
